// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor slice.
// Holds the next-PC select encodings, the 2-bit pattern counter states and
// small helper functions used by the predictor top and its counter sub-module.
package branch_predictor_pkg;

    // Next-PC select encodings driven on brmuxsel
    localparam logic [1:0] SEL_SEQ    = 2'd0;
    localparam logic [1:0] SEL_TGT    = 2'd1;
    localparam logic [1:0] SEL_REC    = 2'd2;
    localparam logic [1:0] SEL_UNUSED = 2'd3;

    // 2-bit saturating counter states
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Width of the statistics counters
    localparam int STAT_W = 16;

    typedef logic [1:0]        ctr2_t;
    typedef logic [STAT_W-1:0] stat_t;

    // Prediction is the MSB of the pattern counter
    function automatic logic ctr_taken(input ctr2_t ctr);
        return ctr[1];
    endfunction

    // Statistics counters stick at all-ones instead of wrapping
    function automatic stat_t stat_inc(input stat_t value);
        stat_t result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Decode/fetch <-> branch predictor connection bundle.
// master: the pipeline side (drives Decode branch info, consumes next-PC
//         control, recovery PC, flush and statistics).
// slave : the predictor side.
interface branch_predictor_if #(
    parameter int PC_W = 32
);
    logic            branchD;
    logic            stallD;
    logic            equalD;
    logic [PC_W-1:0] pcD;
    logic [PC_W-1:0] pcbranchD;
    logic [PC_W-1:0] pcplus1D;

    logic            brbitF;
    logic [1:0]      brmuxsel;
    logic [PC_W-1:0] recoverpc;
    logic            branchCorrect;
    logic            flushD;
    logic [15:0]     brcount;
    logic [15:0]     mispcount;

    modport master (
        output branchD, stallD, equalD, pcD, pcbranchD, pcplus1D,
        input  brbitF, brmuxsel, recoverpc, branchCorrect, flushD, brcount, mispcount
    );

    modport slave (
        input  branchD, stallD, equalD, pcD, pcbranchD, pcplus1D,
        output brbitF, brmuxsel, recoverpc, branchCorrect, flushD, brcount, mispcount
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for one 2-bit saturating pattern counter.
// Ports:
//   cur_s   - current counter value
//   taken_s - resolved branch direction (1 = taken)
//   nxt_s   - updated counter value, saturating at 11 and 00
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cur_s,
    input  logic       taken_s,
    output logic [1:0] nxt_s
);

    // Step toward strongly-taken or strongly-not-taken, holding at the ends
    always_comb begin
        nxt_s = cur_s;
        case (cur_s)
            SNT:     nxt_s = taken_s ? WNT : SNT;
            WNT:     nxt_s = taken_s ? WT  : SNT;
            WT:      nxt_s = taken_s ? ST  : WNT;
            ST:      nxt_s = taken_s ? ST  : WT;
            default: nxt_s = WNT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor for a 5-stage pipeline that resolves branches in
// Decode. A table of 2-bit counters indexed by the low PC bits predicts the
// branch currently in Decode; the outcome is checked one cycle later and a
// mispredict redirects fetch to the correct path and flushes Decode.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - asynchronous active-low reset
//   bp    - slave side of branch_predictor_if (Decode inputs, next-PC
//           control, recovery PC, flush, branch/mispredict statistics)
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int PC_W  = 32
) (
    input  logic         clk,
    input  logic         reset,
    branch_predictor_if.slave bp
);

    localparam int ENTRIES = 1 << IDX_W;

    // Pattern table
    ctr2_t table_r [ENTRIES];

    // Pending (in-flight) branch captured at lookup, resolved next cycle
    logic             pend_valid_r;
    logic [IDX_W-1:0] pend_idx_r;
    logic             pend_pred_r;
    logic             pend_actual_r;
    logic [PC_W-1:0]  pend_tgt_r;
    logic [PC_W-1:0]  pend_seq_r;

    logic [PC_W-1:0]  recover_hold_r;
    stat_t            br_cnt_r;
    stat_t            misp_cnt_r;

    logic [IDX_W-1:0] lookup_idx_s;
    logic             pred_taken_s;
    logic             mispredict_s;
    logic             correct_s;
    logic             lookup_ok_s;
    ctr2_t            upd_ctr_s;

    logic             brbit_s;
    logic [1:0]       brmuxsel_s;
    logic [PC_W-1:0]  recoverpc_s;
    logic             flush_s;

    // Prediction, resolution status and lookup acceptance
    always_comb begin
        lookup_idx_s = bp.pcD[IDX_W-1:0];
        // Read the table before this cycle's update lands: no bypass
        pred_taken_s = ctr_taken(table_r[lookup_idx_s]);
        mispredict_s = pend_valid_r & (pend_pred_r != pend_actual_r);
        correct_s    = pend_valid_r & (pend_pred_r == pend_actual_r);
        // A branch seen during recovery is on the wrong path; reset also
        // gates the lookup so outputs are quiet while reset is held
        lookup_ok_s  = bp.branchD & ~bp.stallD & ~mispredict_s & reset;
    end

    // Counter update for the resolving entry
    sat_counter2 u_sat_counter2 (
        .cur_s   (table_r[pend_idx_r]),
        .taken_s (pend_actual_r),
        .nxt_s   (upd_ctr_s)
    );

    // Next-PC control: recovery wins over a fresh prediction
    always_comb begin
        brbit_s     = 1'b0;
        brmuxsel_s  = SEL_SEQ;
        recoverpc_s = recover_hold_r;
        flush_s     = 1'b0;
        if (mispredict_s) begin
            brmuxsel_s  = SEL_REC;
            flush_s     = 1'b1;
            // Predicted taken means we fetched the target, so fall through
            recoverpc_s = pend_pred_r ? pend_seq_r : pend_tgt_r;
        end else if (lookup_ok_s) begin
            brbit_s    = pred_taken_s;
            brmuxsel_s = pred_taken_s ? SEL_TGT : SEL_SEQ;
        end else begin
            brbit_s    = 1'b0;
            brmuxsel_s = SEL_SEQ;
        end
    end

    assign bp.brbitF        = brbit_s;
    assign bp.brmuxsel      = brmuxsel_s;
    assign bp.recoverpc     = recoverpc_s;
    assign bp.flushD        = flush_s;
    assign bp.branchCorrect = correct_s;
    assign bp.brcount       = br_cnt_r;
    assign bp.mispcount     = misp_cnt_r;

    // Pattern table: weakly not-taken at reset, trained at resolution
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= WNT;
            end
        end else if (pend_valid_r) begin
            table_r[pend_idx_r] <= upd_ctr_s;
        end
    end

    // Pending capture; a branch in flight at reset is simply dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid_r  <= 1'b0;
            pend_idx_r    <= '0;
            pend_pred_r   <= 1'b0;
            pend_actual_r <= 1'b0;
            pend_tgt_r    <= '0;
            pend_seq_r    <= '0;
        end else begin
            pend_valid_r <= lookup_ok_s;
            if (lookup_ok_s) begin
                pend_idx_r    <= lookup_idx_s;
                pend_pred_r   <= pred_taken_s;
                pend_actual_r <= bp.equalD;
                pend_tgt_r    <= bp.pcbranchD;
                pend_seq_r    <= bp.pcplus1D;
            end
        end
    end

    // Keep the last recovery PC visible between mispredicts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            recover_hold_r <= '0;
        end else begin
            recover_hold_r <= recoverpc_s;
        end
    end

    // Resolved-branch and mispredict statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_cnt_r   <= 16'd0;
            misp_cnt_r <= 16'd0;
        end else begin
            if (pend_valid_r) begin
                br_cnt_r <= stat_inc(br_cnt_r);
            end
            if (mispredict_s) begin
                misp_cnt_r <= stat_inc(misp_cnt_r);
            end
        end
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning log2 of pattern-table entries (16 entries).
REQ-002 SHALL have parameter PC_W, default 32, meaning PC width; PCs are word addresses incrementing by 1.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 branchD  in  1  instruction in Decode is a conditional branch.
REQ-006 stallD  in  1  Decode register held this cycle.
REQ-007 equalD  in  1  branch comparison result from Decode.
REQ-008 pcD  in  PC_W  PC of instruction in Decode.
REQ-009 pcbranchD  in  PC_W  branch target computed in Decode.
REQ-010 pcplus1D  in  PC_W  fall-through PC of Decode instruction.
REQ-011 brbitF  out  1  fetch from pcbranchD this cycle (predicted taken).
REQ-012 brmuxsel  out  2  next-PC select: 0 sequential, 1 pcbranchD, 2 recoverpc, 3 unused.
REQ-013 recoverpc  out  PC_W  correct-path PC after a mispredict.
REQ-014 branchCorrect  out  1  resolving branch was predicted correctly (1-cycle pulse).
REQ-015 flushD  out  1  squash wrong-path instruction in Decode.
REQ-016 brcount, mispcount  out  16 each  resolved-branch and mispredict counters.

Function
REQ-017 Pattern table SHALL hold 2^IDX_W 2-bit saturating counters indexed by pcD[IDX_W-1:0]; prediction taken iff counter MSB=1.
REQ-018 Lookup SHALL be combinational: when branchD=1, stallD=0 and no recovery this cycle, brbitF=MSB and brmuxsel=1 if predicted taken else 0.
REQ-019 On an accepted lookup (REQ-018 conditions) the block SHALL capture pending {valid=1, index, predicted, equalD, pcbranchD, pcplus1D}; otherwise pending.valid SHALL clear.
REQ-020 Resolution SHALL occur the cycle after capture (latency 1): actual = captured equalD; branchCorrect = valid & (predicted==actual).
REQ-021 On mispredict (valid & predicted!=actual): brmuxsel=2, flushD=1, brbitF=0, recoverpc = captured pcplus1D if predicted taken else captured pcbranchD.
REQ-022 When no pending mispredict: flushD=0, recoverpc SHALL hold its last value (don't-care to consumers).
REQ-023 Recovery SHALL take priority over a lookup in the same cycle; the Decode branch is wrong-path and SHALL NOT be captured or predicted.
REQ-024 At resolution the indexed counter SHALL increment if actual taken, decrement if not, saturating at 11 and 00.
REQ-025 Update and lookup of the same index in one cycle: lookup SHALL see the pre-update value (no bypass).
REQ-026 brcount SHALL increment on every resolution; mispcount on every mispredict; both saturate at 16'hFFFF.
REQ-027 While stallD=1 the branch SHALL be re-presented each cycle; only the first non-stalled cycle is captured (no duplicate resolution).

Reset
REQ-028 reset low SHALL asynchronously set all counters to 01 (weakly not-taken), pending.valid=0, recoverpc=0, brcount=mispcount=0.
REQ-029 During and after reset: brbitF=0, brmuxsel=0, branchCorrect=0, flushD=0; a pending branch at reset assertion SHALL be discarded without table update.

Structure
REQ-030 Shared package SHALL hold brmuxsel encodings (SEL_SEQ=0, SEL_TGT=1, SEL_REC=2) and counter constants (SNT=00, WNT=01, WT=10, ST=11).
REQ-031 The 2-bit saturating counter update SHALL be one sub-module, sat_counter2, instantiated combinationally on the update path.

Verification
REQ-032 After reset, branch at pcD=5, equalD=1 -> cycle0 brmuxsel=0; cycle1 brmuxsel=2, recoverpc=captured pcbranchD, flushD=1, mispcount=1; entry5=10.
REQ-033 Repeat same branch taken: second visit brbitF=1, brmuxsel=1; next cycle branchCorrect=1, entry5=11; third taken leaves entry5=11.
REQ-034 Entry5=11, equalD=0 -> brmuxsel=2, recoverpc=pcplus1D (6), entry5=10.
REQ-035 Mispredict cycle with new branch in Decode -> no capture, next cycle branchCorrect=0, brcount unchanged by the squashed branch.
REQ-036 Branch held 3 cycles with stallD=1 then released -> exactly one resolution, brcount+1.
REQ-037 Assert reset while pending valid -> outputs 0 immediately, counters return to 01, no update.
